mux2_stream_arbiter: RTL and testbench

//   Upstream control stage for the 2:1 bit mux. Arbitrates between two valid/ready

---
 rtl/mux2_arb_pkg.sv | 21 ++
 rtl/mux2_stream_arbiter_mux2_bit.sv | 19 +
 rtl/mux2_stream_arbiter.sv | 133 +++++++++++++
 tb/tb_mux2_stream_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// ============================================================================
// Module : mux2_arb_pkg
// Brief  : Shared types and select encodings for the 2:1 stream arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux2_stream_arbiter_mux2_bit.sv
// ============================================================================
// Module : mux2_bit
// Brief  : Single-bit 2:1 mux slice, sel=0 picks a, sel=1 picks b.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2_bit (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);

   assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux2_stream_arbiter.sv
// ============================================================================
// Module : mux2_stream_arbiter
// Brief  : Round-robin, packet-locked arbiter of two valid/ready streams into
//          one registered output stream through per-bit mux slices.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2_stream_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   input  logic             a_last,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   input  logic             b_last,
   output logic             b_ready,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic             r_rr_ptr;
   logic             w_rr_nxt;
   logic             r_sel;
   logic             w_sel_nxt;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_out_last;
   logic [WIDTH-1:0] w_mux_data;
   logic             w_mux_last;
   logic             w_space;
   logic             w_acc;

   // The granted source is already on sel, so the slices present its beat.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_slice
         mux2_bit u_slice (
            .a   (a_data[i]),
            .b   (b_data[i]),
            .sel (r_sel),
            .y   (w_mux_data[i])
         );
      end
   endgenerate

   mux2_bit u_last (
      .a   (a_last),
      .b   (b_last),
      .sel (r_sel),
      .y   (w_mux_last)
   );

   assign w_space = !r_out_valid || out_ready;
   assign a_ready = (r_state == GRANT_A) && w_space;
   assign b_ready = (r_state == GRANT_B) && w_space;
   assign w_acc   = (a_valid && a_ready) || (b_valid && b_ready);

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_sel_nxt   = r_sel;
      case (r_state)
         IDLE: begin
            if (a_valid && (!b_valid || r_rr_ptr == SEL_A)) begin
               w_state_nxt = GRANT_A;
               w_sel_nxt   = SEL_A;
            end else if (b_valid) begin
               w_state_nxt = GRANT_B;
               w_sel_nxt   = SEL_B;
            end
         end
         GRANT_A: begin
            if (w_acc && w_mux_last) begin
               w_state_nxt = IDLE;
               w_rr_nxt    = SEL_B;
            end
         end
         GRANT_B: begin
            if (w_acc && w_mux_last) begin
               w_state_nxt = IDLE;
               w_rr_nxt    = SEL_A;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_rr_ptr <= SEL_A;
         r_sel    <= SEL_A;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_sel    <= w_sel_nxt;
      end
   end

   // A load in the same cycle as a drain replaces the beat and keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_acc) begin
         r_out_data  <= w_mux_data;
         r_out_last  <= w_mux_last;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign sel       = r_sel;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_mux2_stream_arbiter.sv
// ============================================================================
// Module : tb_mux2_stream_arbiter
// Brief  : Self-checking bench: producer packet queues, randomized handshakes,
//          transaction-level reference model of grants and the output slot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux2_stream_arbiter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a_data, b_data, out_data;
   logic             a_valid, a_last, a_ready;
   logic             b_valid, b_last, b_ready;
   logic             sel, out_valid, out_last, out_ready;

   mux2_stream_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_last    (a_last),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_last    (b_last),
      .b_ready   (b_ready),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Producer packet queues, each entry {last, data}; beats leave only when accepted.
   logic [WIDTH:0] qa[$];
   logic [WIDTH:0] qb[$];

   // Model: who owns the output (0 none, 1 A, 2 B), who wins the next tie,
   // current select, and the single output slot.
   int             m_owner;
   bit             m_next_b;
   bit             m_sel;
   bit             m_ov;
   bit             m_ol;
   logic [WIDTH-1:0] m_od;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_next_b = 1'b0;
      m_sel    = 1'b0;
      m_ov     = 1'b0;
      m_ol     = 1'b0;
      m_od     = '0;
   endtask

   task automatic push_pkt(input bit to_b, input int len, input bit rnd, input logic [WIDTH-1:0] base);
      for (int i = 0; i < len; i++) begin
         logic [WIDTH-1:0] d;
         d = rnd ? WIDTH'($urandom) : base + WIDTH'(i);
         if (to_b) qb.push_back({(i == len - 1), d});
         else      qa.push_back({(i == len - 1), d});
      end
   endtask

   task automatic reset_checks();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_last",  out_last,  0);
      check("rst_a_ready",   a_ready,   0);
      check("rst_b_ready",   b_ready,   0);
      check("rst_sel",       sel,       0);
   endtask

   // Asynchronous reset in the middle of a cycle; partial packets are discarded.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      qa.delete();
      qb.delete();
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n   = 1'b1;
   endtask

   task automatic cycle(input int pa, input int pb, input int pr);
      bit ea, eb, acc_a, acc_b, was_idle;
      @(negedge clk);
      a_valid = (qa.size() > 0) && ($urandom_range(99) < pa);
      b_valid = (qb.size() > 0) && ($urandom_range(99) < pb);
      if (qa.size() > 0) {a_last, a_data} = qa[0];
      if (qb.size() > 0) {b_last, b_data} = qb[0];
      out_ready = ($urandom_range(99) < pr);
      #1;
      ea = (m_owner == 1) && (!m_ov || out_ready);
      eb = (m_owner == 2) && (!m_ov || out_ready);
      check("a_ready",   a_ready,   ea);
      check("b_ready",   b_ready,   eb);
      check("sel",       sel,       m_sel);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
         check("out_data", out_data, m_od);
         check("out_last", out_last, m_ol);
      end
      acc_a    = a_valid && ea;
      acc_b    = b_valid && eb;
      was_idle = (m_owner == 0);
      if (acc_a || acc_b) begin
         logic [WIDTH:0] beat;
         beat = acc_a ? qa.pop_front() : qb.pop_front();
         {m_ol, m_od} = beat;
         m_ov = 1'b1;
         if (m_ol) begin
            m_next_b = acc_a;
            m_owner  = 0;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (was_idle) begin
         if (a_valid && !(b_valid && m_next_b)) begin
            m_owner = 1;
            m_sel   = 1'b0;
         end else if (b_valid) begin
            m_owner = 2;
            m_sel   = 1'b1;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((qa.size() > 0 || qb.size() > 0 || m_ov) && k < 2000) begin
         cycle(85, 85, 75);
         k++;
      end
      check("drain_in_budget", (k < 2000), 1);
   endtask

   initial begin
      $monitor("%0t av=%b bv=%b ar=%b br=%b sel=%b ov=%b od=%02h ol=%b",
               $time, a_valid, b_valid, a_ready, b_ready, sel, out_valid, out_data, out_last);
      model_reset();
      a_data = 8'h5A; b_data = 8'hA5; a_last = 1'b0; b_last = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      reset_checks();
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n   = 1'b1;

      // A-only three-beat packet, full rate
      qa.push_back({1'b0, 8'h11});
      qa.push_back({1'b0, 8'h22});
      qa.push_back({1'b1, 8'h33});
      repeat (8) cycle(100, 0, 100);

      // contention straight after reset: A first, then B
      do_reset();
      qa.push_back({1'b0, 8'hA1});
      qa.push_back({1'b1, 8'hA2});
      qb.push_back({1'b0, 8'hB1});
      qb.push_back({1'b1, 8'hB2});
      repeat (10) cycle(100, 100, 100);

      // backpressure held for three cycles mid-packet
      push_pkt(1'b0, 5, 1'b0, 8'h40);
      repeat (3) cycle(100, 0, 100);
      repeat (3) cycle(100, 0, 0);
      drain();

      // B owns the output while A waits; B valid has gaps
      push_pkt(1'b1, 4, 1'b0, 8'hC0);
      repeat (2) cycle(0, 100, 100);
      push_pkt(1'b0, 2, 1'b0, 8'hD0);
      repeat (20) cycle(100, 33, 100);
      drain();

      // reset lands on beat 2 of a 4-beat A packet, then a clean B packet
      push_pkt(1'b0, 4, 1'b0, 8'hE0);
      repeat (3) cycle(100, 0, 100);
      do_reset();
      push_pkt(1'b1, 3, 1'b0, 8'hF0);
      drain();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if (qa.size() < 8 && $urandom_range(3) == 0) push_pkt(1'b0, $urandom_range(1, 4), 1'b1, 8'h00);
         if (qb.size() < 8 && $urandom_range(3) == 0) push_pkt(1'b1, $urandom_range(1, 4), 1'b1, 8'h00);
         cycle(70, 70, 60);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
